// File: rtl/ctrl_reg_banked.sv
// rtl/ctrl_reg_banked.sv - banked flash window, RAM enables, maprom and boot overlay control register
// One commit per Z2 data phase; bank reprogramming needs the KEY1/KEY2 unlock sequence first.
module ctrl_reg_banked #(
    parameter int         NUM_BANKS = 4,
    parameter int         NUM_EN    = 3,
    parameter logic [3:0] KEY1      = 4'hA,
    parameter logic [3:0] KEY2      = 4'h5,
    parameter logic [7:0] CIA_PAGE  = 8'hBF,
    parameter logic [1:0] Z2_DATA   = 2'd2,
    localparam int        BANK_BITS = $clog2(NUM_BANKS)
) (
    input  logic                 CLK,
    input  logic                 RESET_n,
    input  logic                 AS_n,
    input  logic [23:1]          ADDR,
    input  logic [15:12]         DIN,
    input  logic                 RW,
    input  logic                 ctrl_access,
    input  logic [1:0]           z2_state,
    input  logic                 flash_enabled,
    input  logic [BANK_BITS-1:0] flash_bank,
    output logic [BANK_BITS-1:0] flash_ahi,
    output logic                 flash_a18,
    output logic [3:0]           DOUT,
    output logic [NUM_EN-1:0]    en,
    output logic                 mapram_en,
    output logic                 OVL,
    output logic                 dtack
);

    typedef enum logic [1:0] {
        KEY_LOCKED   = 2'd0,
        KEY_KEY1_OK  = 2'd1,
        KEY_UNLOCKED = 2'd2
    } key_state_t;

    localparam logic [1:0] REG_CTRL     = 2'd0;
    localparam logic [1:0] REG_PROGBANK = 2'd1;
    localparam logic [1:0] REG_MAP      = 2'd2;

    key_state_t           key_state;
    logic [BANK_BITS-1:0] progbank;
    logic [1:0]           reg_sel;
    logic                 in_phase;
    logic                 commit;
    logic                 ovl_clear;
    logic                 unused_addr;

    assign reg_sel     = ADDR[2:1];
    assign in_phase    = (z2_state == Z2_DATA) && ctrl_access;
    assign commit      = in_phase && !dtack;
    assign ovl_clear   = (ADDR[23:16] == CIA_PAGE) && !RW && !AS_n;
    assign unused_addr = ^ADDR[15:3];

    always_ff @(posedge CLK) begin
        if (!RESET_n) begin
            progbank  <= '0;
            en        <= '0;
            mapram_en <= 1'b0;
            OVL       <= 1'b1;
            dtack     <= 1'b0;
            key_state <= KEY_LOCKED;
        end else begin
            // dtack rises on the commit edge and holds until the phase ends
            dtack <= in_phase;
            if (ovl_clear) begin
                OVL <= 1'b0;
            end
            if (commit) begin
                case (reg_sel)
                    REG_CTRL: begin
                        if (!RW) begin
                            for (int i = 0; i < NUM_EN; i++) begin
                                if (DIN[13+i]) begin
                                    en[i] <= DIN[12];
                                end
                            end
                        end
                        if (key_state == KEY_KEY1_OK) begin
                            key_state <= KEY_LOCKED;
                        end
                    end
                    REG_PROGBANK: begin
                        if (!RW && key_state == KEY_UNLOCKED) begin
                            progbank  <= DIN[12 +: BANK_BITS];
                            key_state <= KEY_LOCKED;
                        end
                    end
                    REG_MAP: begin
                        if (!RW && DIN[15]) begin
                            mapram_en <= 1'b1;
                        end
                        if (key_state == KEY_KEY1_OK) begin
                            key_state <= KEY_LOCKED;
                        end
                    end
                    default: begin
                        // reads of the KEY register leave the sequence untouched
                        if (!RW) begin
                            case (key_state)
                                KEY_LOCKED:  key_state <= (DIN == KEY1) ? KEY_KEY1_OK : KEY_LOCKED;
                                KEY_KEY1_OK: key_state <= (DIN == KEY2) ? KEY_UNLOCKED : KEY_LOCKED;
                                default:     key_state <= KEY_LOCKED;
                            endcase
                        end
                    end
                endcase
            end
        end
    end

    always_comb begin
        DOUT = 4'h0;
        case (reg_sel)
            REG_CTRL:     DOUT[NUM_EN-1:0]    = en;
            REG_PROGBANK: DOUT[BANK_BITS-1:0] = progbank;
            REG_MAP:      DOUT = {mapram_en, flash_enabled & ~mapram_en, OVL, key_state == KEY_UNLOCKED};
            default:      DOUT = {2'b00, key_state};
        endcase
    end

    assign flash_ahi = (flash_enabled && !mapram_en) ? flash_bank : progbank;
    assign flash_a18 = (OVL && !ADDR[23]) ? 1'b1 : ADDR[19];

endmodule

// File: tb/tb_ctrl_reg_banked.sv
// tb/tb_ctrl_reg_banked.sv - directed vector table, handshake sequences and randomized model check
module tb_ctrl_reg_banked;

    localparam logic [1:0]  D    = 2'd2;
    localparam logic [23:0] A_C  = 24'hE80000;
    localparam logic [23:0] A_P  = 24'hE80002;
    localparam logic [23:0] A_M  = 24'hE80004;
    localparam logic [23:0] A_K  = 24'hE80006;
    localparam logic [23:0] A_LO = 24'h000004;
    localparam logic [23:0] A_CI = 24'hBFE000;

    logic        CLK = 1'b0;
    logic        RESET_n, AS_n, RW, ctrl_access, flash_enabled;
    logic [23:1] ADDR;
    logic [15:12] DIN;
    logic [1:0]  z2_state, flash_bank, flash_ahi;
    logic        flash_a18, mapram_en, OVL, dtack;
    logic [3:0]  DOUT;
    logic [2:0]  en;

    ctrl_reg_banked dut (
        .CLK(CLK), .RESET_n(RESET_n), .AS_n(AS_n), .ADDR(ADDR), .DIN(DIN), .RW(RW),
        .ctrl_access(ctrl_access), .z2_state(z2_state), .flash_enabled(flash_enabled),
        .flash_bank(flash_bank), .flash_ahi(flash_ahi), .flash_a18(flash_a18), .DOUT(DOUT),
        .en(en), .mapram_en(mapram_en), .OVL(OVL), .dtack(dtack)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        rst_n;
        logic [1:0]  z2;
        logic        acc;
        logic        rw;
        logic [23:0] addr;
        logic [3:0]  din;
        logic        fe;
        logic [1:0]  fb;
        logic [12:0] exp;
    } row_t;
    row_t tbl[$];

    // reference state: what the register map holds, not how the RTL encodes it
    logic [2:0] m_en;
    logic [1:0] m_pb;
    bit         m_map, m_ovl, m_acked;
    int         m_key;

    function automatic void add(input logic rst_n, input logic [1:0] z2, input logic acc, input logic rw,
                                input logic [23:0] addr, input logic [3:0] din, input logic fe,
                                input logic [1:0] fb, input logic e_dt, input logic [3:0] e_dout,
                                input logic [2:0] e_en, input logic e_map, input logic e_ovl,
                                input logic [1:0] e_ahi, input logic e_a18);
        row_t r;
        r.rst_n = rst_n; r.z2 = z2; r.acc = acc; r.rw = rw; r.addr = addr; r.din = din;
        r.fe = fe; r.fb = fb;
        r.exp = {e_dt, e_dout, e_en, e_map, e_ovl, e_ahi, e_a18};
        tbl.push_back(r);
    endfunction

    function automatic logic [12:0] snap();
        return {dtack, DOUT, en, mapram_en, OVL, flash_ahi, flash_a18};
    endfunction

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic drv(input logic rst, input logic [1:0] z2, input logic acc, input logic rw,
                       input logic [23:0] a, input logic [3:0] d, input logic fe, input logic [1:0] fb);
        RESET_n = rst; z2_state = z2; ctrl_access = acc; RW = rw; ADDR = a[23:1]; DIN = d;
        flash_enabled = fe; flash_bank = fb; AS_n = !(z2 == D);
    endtask

    function automatic void model_step();
        int sel;
        bit in_phase;
        if (!RESET_n) begin
            m_en = 0; m_pb = 0; m_map = 0; m_ovl = 1; m_acked = 0; m_key = 0;
            return;
        end
        in_phase = (z2_state == D) && ctrl_access;
        if (ADDR[23:16] == 8'hBF && !RW && !AS_n) m_ovl = 0;
        if (in_phase && !m_acked) begin
            sel = int'(ADDR[2:1]);
            if (sel == 3) begin
                if (!RW) m_key = (m_key == 0 && DIN == 4'hA) ? 1 : (m_key == 1 && DIN == 4'h5) ? 2 : 0;
            end else if (sel == 1) begin
                if (!RW && m_key == 2) begin m_pb = DIN[13:12]; m_key = 0; end
            end else begin
                if (m_key == 1) m_key = 0;
                if (!RW && sel == 0) m_en = DIN[12] ? (m_en | DIN[15:13]) : (m_en & ~DIN[15:13]);
                if (!RW && sel == 2 && DIN[15]) m_map = 1;
            end
            m_acked = 1;
        end else if (!in_phase) begin
            m_acked = 0;
        end
    endfunction

    function automatic logic [12:0] model_exp();
        logic [3:0] dout;
        logic [1:0] ahi;
        logic       a18;
        case (int'(ADDR[2:1]))
            0:       dout = {1'b0, m_en};
            1:       dout = {2'b00, m_pb};
            2:       dout = {m_map, flash_enabled & !m_map, m_ovl, m_key == 2};
            default: dout = 4'(m_key);
        endcase
        ahi = (flash_enabled && !m_map) ? flash_bank : m_pb;
        a18 = (m_ovl && !ADDR[23]) ? 1'b1 : ADDR[19];
        return {m_acked, dout, m_en, m_map, m_ovl, ahi, a18};
    endfunction

    task automatic step();
        model_step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [31:0] r32;
        logic [23:0] a;
        drv(0, 0, 0, 1, A_C, 0, 0, 0);

        // rst z2 acc rw addr din fe fb | dtack dout en map ovl ahi a18
        add(0, 0, 0, 1, A_C,  4'h0, 0, 0,  0, 4'h0, 3'b000, 0, 1, 0, 1);
        add(1, 0, 0, 1, A_C,  4'h0, 0, 0,  0, 4'h0, 3'b000, 0, 1, 0, 1);
        add(1, D, 1, 0, A_C,  4'hB, 0, 0,  1, 4'h5, 3'b101, 0, 1, 0, 1);
        add(1, 0, 0, 1, A_C,  4'h0, 0, 0,  0, 4'h5, 3'b101, 0, 1, 0, 1);
        add(1, D, 1, 0, A_C,  4'h2, 0, 0,  1, 4'h4, 3'b100, 0, 1, 0, 1);
        add(1, 0, 0, 1, A_C,  4'h0, 0, 0,  0, 4'h4, 3'b100, 0, 1, 0, 1);
        add(1, D, 1, 0, A_P,  4'h3, 0, 0,  1, 4'h0, 3'b100, 0, 1, 0, 1);
        add(1, 0, 0, 1, A_P,  4'h0, 0, 0,  0, 4'h0, 3'b100, 0, 1, 0, 1);
        add(1, D, 1, 0, A_K,  4'hA, 0, 0,  1, 4'h1, 3'b100, 0, 1, 0, 1);
        add(1, 0, 0, 1, A_K,  4'h0, 0, 0,  0, 4'h1, 3'b100, 0, 1, 0, 1);
        add(1, D, 1, 0, A_K,  4'h5, 0, 0,  1, 4'h2, 3'b100, 0, 1, 0, 1);
        add(1, 0, 0, 1, A_K,  4'h0, 0, 0,  0, 4'h2, 3'b100, 0, 1, 0, 1);
        add(1, D, 1, 0, A_P,  4'h3, 0, 0,  1, 4'h3, 3'b100, 0, 1, 3, 1);
        add(1, 0, 0, 1, A_K,  4'h0, 0, 0,  0, 4'h0, 3'b100, 0, 1, 3, 1);
        add(1, D, 1, 0, A_K,  4'hA, 0, 0,  1, 4'h1, 3'b100, 0, 1, 3, 1);
        add(1, 0, 0, 1, A_K,  4'h0, 0, 0,  0, 4'h1, 3'b100, 0, 1, 3, 1);
        add(1, D, 1, 0, A_C,  4'h0, 0, 0,  1, 4'h4, 3'b100, 0, 1, 3, 1);
        add(1, 0, 0, 1, A_K,  4'h0, 0, 0,  0, 4'h0, 3'b100, 0, 1, 3, 1);
        add(1, D, 1, 0, A_K,  4'h5, 0, 0,  1, 4'h0, 3'b100, 0, 1, 3, 1);
        add(1, 0, 0, 1, A_K,  4'h0, 0, 0,  0, 4'h0, 3'b100, 0, 1, 3, 1);
        add(1, D, 1, 0, A_P,  4'h1, 0, 0,  1, 4'h3, 3'b100, 0, 1, 3, 1);
        add(1, 0, 0, 1, A_P,  4'h0, 0, 0,  0, 4'h3, 3'b100, 0, 1, 3, 1);
        add(1, 0, 0, 1, A_M,  4'h0, 1, 2,  0, 4'h6, 3'b100, 0, 1, 2, 1);
        add(1, D, 1, 0, A_M,  4'h8, 1, 2,  1, 4'hA, 3'b100, 1, 1, 3, 1);
        add(1, 0, 0, 1, A_M,  4'h0, 1, 2,  0, 4'hA, 3'b100, 1, 1, 3, 1);
        add(1, D, 1, 0, A_C,  4'hE, 1, 2,  1, 4'h0, 3'b000, 1, 1, 3, 1);
        add(1, 0, 0, 1, A_C,  4'h0, 1, 2,  0, 4'h0, 3'b000, 1, 1, 3, 1);
        add(1, D, 1, 1, A_LO, 4'h0, 0, 0,  1, 4'hA, 3'b000, 1, 1, 3, 1);
        add(1, 0, 0, 1, A_LO, 4'h0, 0, 0,  0, 4'hA, 3'b000, 1, 1, 3, 1);
        add(1, D, 0, 1, A_CI, 4'h0, 0, 0,  0, 4'h0, 3'b000, 1, 1, 3, 1);
        add(1, D, 1, 0, A_CI, 4'h3, 0, 0,  1, 4'h1, 3'b001, 1, 0, 3, 1);
        add(1, 0, 0, 1, A_LO, 4'h0, 0, 0,  0, 4'h8, 3'b001, 1, 0, 3, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            drv(tbl[i].rst_n, tbl[i].z2, tbl[i].acc, tbl[i].rw, tbl[i].addr, tbl[i].din, tbl[i].fe, tbl[i].fb);
            step();
            chk($sformatf("vec%0d", i), {3'b000, snap()}, {3'b000, tbl[i].exp});
        end

        // long data phase: one commit only, so KEY1 must not be taken twice
        drv(1, D, 1, 0, A_K, 4'hA, 0, 0);
        #1;
        chk("hold_pre_dtack", {15'd0, dtack}, 16'd0);
        for (int c = 0; c < 5; c++) begin
            step();
            chk($sformatf("hold_dtack_c%0d", c + 1), {15'd0, dtack}, 16'd1);
        end
        chk("hold_single_commit", {12'd0, DOUT}, 16'd1);
        drv(1, 0, 0, 1, A_K, 4'h0, 0, 0);
        step();
        chk("hold_release", {15'd0, dtack}, 16'd0);

        // reset in the middle of a phase, then a fresh commit after release
        drv(1, D, 1, 0, A_K, 4'hA, 0, 0);
        step();
        chk("mid_pre_lock", {11'd0, dtack, DOUT}, {11'd0, 1'b1, 4'h0});
        RESET_n = 1'b0;
        step();
        chk("mid_reset", {3'd0, snap()}, {3'd0, 1'b0, 4'h0, 3'b000, 1'b0, 1'b1, 2'd0, 1'b1});
        RESET_n = 1'b1;
        step();
        chk("mid_recommit", {11'd0, dtack, DOUT}, {11'd0, 1'b1, 4'h1});
        step();
        chk("mid_hold", {11'd0, dtack, DOUT}, {11'd0, 1'b1, 4'h1});
        ctrl_access = 1'b0;
        step();
        chk("acc_drop", {15'd0, dtack}, 16'd0);
        ctrl_access = 1'b1;
        step();
        chk("acc_new_phase", {11'd0, dtack, DOUT}, {11'd0, 1'b1, 4'h0});

        drv(0, 0, 0, 1, A_C, 0, 0, 0);
        step();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 1) == 0 || c == 0) begin
                r32 = $urandom();
                a = r32[23:0];
                case ($urandom_range(0, 3))
                    0:       a[23:16] = 8'hBF;
                    1:       a[23:16] = 8'hE8;
                    2:       a[23:16] = 8'h00;
                    default: ;
                endcase
                RESET_n = ($urandom_range(0, 99) != 0);
                z2_state = ($urandom_range(0, 1) == 0) ? D : 2'($urandom_range(0, 3));
                ctrl_access = ($urandom_range(0, 3) != 0);
                RW = 1'($urandom_range(0, 1));
                AS_n = ($urandom_range(0, 3) == 0);
                ADDR = a[23:1];
                case ($urandom_range(0, 2))
                    0:       DIN = 4'hA;
                    1:       DIN = 4'h5;
                    default: DIN = 4'($urandom_range(0, 15));
                endcase
                flash_enabled = 1'($urandom_range(0, 1));
                flash_bank = 2'($urandom_range(0, 3));
            end
            step();
            chk($sformatf("rand%0d", c), {3'd0, snap()}, {3'd0, model_exp()});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
